motor_drive_scheduler: RTL
==========================

# motor_drive_scheduler

Sequences and shares the robot's two motor-drive outputs (Z1 forward, Z2 brake) between an emergency stop, a manual-override requester and the automatic sensor-FSM requester. Sits between the sensor-driven robot control FSM and the motor driver pins. Enforces a minimum hold time per drive state and a dead-time (both outputs low) on every forward↔brake reversal, so the driver never sees Z1 and Z2 high together or chattering commands.

## Interface
- DEAD_CYCLES, default 4: cycles both outputs are held low on a forward↔brake reversal; legal range ≥1.
- MIN_HOLD, default 8: minimum cycles spent in FORWARD or BRAKE before leaving it; legal range ≥1.
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock, one reset, no other reset path.
- estop  in  1  emergency stop, level; highest priority, forces BRAKE target.
- man_valid  in  1  manual requester active, level.
- man_cmd  in  2  manual command {Z2,Z1}: 00 idle, 01 forward, 10 brake, 11 illegal.
- auto_valid  in  1  sensor-FSM requester active, level.
- auto_cmd  in  2  sensor-FSM command, same encoding.
- Z1  out  1  forward drive, registered.
- Z2  out  1  brake drive, registered.
- man_gnt  out  1  manual requester won arbitration last cycle.
- auto_gnt  out  1  auto requester won arbitration last cycle.
- busy  out  1  state is DEAD, or target ≠ current drive and blocked by MIN_HOLD.
- cmd_err  out  1  one-cycle pulse: winning command was 11.

## Operation
- Target selection each cycle, fixed priority: estop → brake (10); else man_valid → man_cmd; else auto_valid → auto_cmd; else idle (00). Winning 11 → target idle, cmd_err=1 next cycle.
- Grants one-hot or zero, registered; estop cycles assert neither grant.
- States: IDLE (Z=00), FORWARD (Z1=1), BRAKE (Z2=1), DEAD (Z=00). Z1&Z2 never both 1.
- hold_cnt: cleared on entry to FORWARD/BRAKE, increments per cycle, saturates at MIN_HOLD. "Hold met" = hold_cnt == MIN_HOLD, or estop=1.
- IDLE: target forward → FORWARD; brake → BRAKE; idle → stay.
- FORWARD: target forward → stay; target idle and hold met → IDLE; target brake and hold met → DEAD; otherwise stay (busy=1).
- BRAKE: symmetric to FORWARD with forward as the opposite direction.
- DEAD: dead_cnt counts 1..DEAD_CYCLES; on the cycle it reaches DEAD_CYCLES, move to the then-current target (IDLE/FORWARD/BRAKE). Target changes during DEAD do not shorten or restart it.
- estop bypasses MIN_HOLD only; never bypasses DEAD.
- reset mid-operation (including DEAD): next edge → IDLE, counters 0, all outputs 0.

## Timing
- Reset values: Z1=0, Z2=0, man_gnt=0, auto_gnt=0, busy=0, cmd_err=0, state IDLE.
- Target sampled combinationally in cycle t; state/outputs update at edge ending t (1-cycle latency).
- Reversal FORWARD→BRAKE with hold met: Z=00 for exactly DEAD_CYCLES cycles, Z2=1 on cycle DEAD_CYCLES+1.
- Counter widths: $clog2(MIN_HOLD+1), $clog2(DEAD_CYCLES+1); no wrap.
- Simultaneous estop+man_valid+auto_valid: estop wins, no grant asserted.

## Structure
- Shared package robot_ctrl_pkg: drive command enum (CMD_IDLE, CMD_FWD, CMD_BRAKE, CMD_ILLEGAL) and state enum (S_IDLE, S_FWD, S_BRAKE, S_DEAD); reused by the sensor FSM.
- One sub-module: motor_req_arbiter (combinational priority select + illegal-command detect; outputs target, winner, err). Scheduler FSM, counters and output registers in top.

## Test plan
- Reset: assert reset 2 cycles while auto_valid=1, auto_cmd=01 → Z=00, grants 0; release → Z1=1, auto_gnt=1 one cycle later.
- Hold: FORWARD entered, auto_cmd→00 after 3 cycles → Z1 stays 1 until hold_cnt=8, busy=1 meanwhile, then Z=00.
- Reversal: FORWARD held 10 cycles, auto_cmd→10 → Z=00 for 4 cycles, then Z2=1; Z1&Z2 never 1.
- Priority: auto 01 and man 10 together from IDLE → BRAKE, man_gnt=1, auto_gnt=0; add estop → grants 0, brake stays.
- estop: FORWARD after 2 cycles, estop=1 → no hold wait, Z=00 next cycle for 4 cycles, then Z2=1.
- Illegal: man_cmd=11 with man_valid=1 from FORWARD (hold met) → cmd_err one-cycle pulse, Z goes 00; reset asserted during DEAD → IDLE next edge.

Source files
------------

// File: rtl/robot_ctrl_pkg.sv
// Shared types for the robot controller: drive commands, drive states and
// requester identities, plus a command-to-state helper.
package robot_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE    = 2'b00,
    CMD_FWD     = 2'b01,
    CMD_BRAKE   = 2'b10,
    CMD_ILLEGAL = 2'b11
  } drive_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_BRAKE,
    S_DEAD
  } drive_state_t;

  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_ESTOP,
    WIN_MAN,
    WIN_AUTO
  } req_winner_t;

  function automatic drive_state_t cmd_to_state(input drive_cmd_t cmd);
    case (cmd)
      CMD_FWD:   return S_FWD;
      CMD_BRAKE: return S_BRAKE;
      default:   return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/motor_req_arbiter.sv
// Fixed-priority select between estop, manual and automatic requesters.
// An illegal winning command is reported and degraded to an idle target.
module motor_req_arbiter
  import robot_ctrl_pkg::*;
(
  input  logic        estop,
  input  logic        man_valid,
  input  logic [1:0]  man_cmd,
  input  logic        auto_valid,
  input  logic [1:0]  auto_cmd,
  output drive_cmd_t  target,
  output req_winner_t winner,
  output logic        err
);

  always_comb begin
    target = CMD_IDLE;
    winner = WIN_NONE;
    err    = 1'b0;
    if (estop) begin
      target = CMD_BRAKE;
      winner = WIN_ESTOP;
    end else if (man_valid) begin
      winner = WIN_MAN;
      if (man_cmd == CMD_ILLEGAL) err = 1'b1;
      else                        target = drive_cmd_t'(man_cmd);
    end else if (auto_valid) begin
      winner = WIN_AUTO;
      if (auto_cmd == CMD_ILLEGAL) err = 1'b1;
      else                         target = drive_cmd_t'(auto_cmd);
    end
  end

endmodule

// File: rtl/motor_drive_scheduler.sv
// Drive-state scheduler: enforces minimum hold per drive direction and a
// dead-time with both outputs low on every forward/brake reversal.
module motor_drive_scheduler
  import robot_ctrl_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 4,
  parameter int unsigned MIN_HOLD    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       estop,
  input  logic       man_valid,
  input  logic [1:0] man_cmd,
  input  logic       auto_valid,
  input  logic [1:0] auto_cmd,
  output logic       Z1,
  output logic       Z2,
  output logic       man_gnt,
  output logic       auto_gnt,
  output logic       busy,
  output logic       cmd_err
);

  localparam int HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_CYCLES);

  drive_cmd_t   target;
  req_winner_t  winner;
  logic         err;

  drive_state_t      state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [DEAD_W-1:0] dead_cnt_reg, dead_cnt_next;
  logic              z1_reg, z2_reg, man_gnt_reg, auto_gnt_reg, cmd_err_reg;
  drive_cmd_t        own_cmd;
  logic              hold_met;

  motor_req_arbiter u_arbiter (
    .estop      (estop),
    .man_valid  (man_valid),
    .man_cmd    (man_cmd),
    .auto_valid (auto_valid),
    .auto_cmd   (auto_cmd),
    .target     (target),
    .winner     (winner),
    .err        (err)
  );

  // estop relaxes the hold requirement but never the dead-time
  assign hold_met = (hold_cnt_reg == HOLD_MAX) || estop;

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
    dead_cnt_next = dead_cnt_reg;
    own_cmd       = CMD_IDLE;
    busy          = 1'b0;
    case (state_reg)
      S_IDLE: begin
        hold_cnt_next = '0;
        dead_cnt_next = '0;
        state_next    = cmd_to_state(target);
      end
      S_FWD, S_BRAKE: begin
        if (state_reg == S_FWD) own_cmd = CMD_FWD;
        else                    own_cmd = CMD_BRAKE;
        if (target != own_cmd) begin
          if (!hold_met) begin
            busy = 1'b1;
          end else if (target == CMD_IDLE) begin
            state_next = S_IDLE;
          end else begin
            state_next    = S_DEAD;
            dead_cnt_next = DEAD_W'(1);
          end
        end
      end
      S_DEAD: begin
        busy          = 1'b1;
        hold_cnt_next = '0;
        if (dead_cnt_reg == DEAD_MAX) begin
          state_next    = cmd_to_state(target);
          dead_cnt_next = '0;
        end else begin
          dead_cnt_next = dead_cnt_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      hold_cnt_reg <= '0;
      dead_cnt_reg <= '0;
      z1_reg       <= 1'b0;
      z2_reg       <= 1'b0;
      man_gnt_reg  <= 1'b0;
      auto_gnt_reg <= 1'b0;
      cmd_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      dead_cnt_reg <= dead_cnt_next;
      z1_reg       <= (state_next == S_FWD);
      z2_reg       <= (state_next == S_BRAKE);
      man_gnt_reg  <= (winner == WIN_MAN);
      auto_gnt_reg <= (winner == WIN_AUTO);
      cmd_err_reg  <= err;
    end
  end

  assign Z1       = z1_reg;
  assign Z2       = z2_reg;
  assign man_gnt  = man_gnt_reg;
  assign auto_gnt = auto_gnt_reg;
  assign cmd_err  = cmd_err_reg;

endmodule
